// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core-side request/response handshake bundle for load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V style load/store unit with read-modify-write for byte/half stores.
// Define LSU_SUBWORD_EN to enable LB/LH/LBU/LHU/SB/SH; otherwise only LW/SW are legal.
module load_store_unit #(
  parameter int MEM_WORDS = 15
) (
  input  logic               CLK,
  input  logic               RST_N,
  load_store_unit_if.slave   bus,
  output logic               WE,
  output logic [31:0]        A,
  output logic [31:0]        WD,
  input  logic [31:0]        RD
);
  typedef enum logic [2:0] {IDLE, READ, RMW_RD, WRITE, RESP} state_t;
  state_t      state;
  logic        st;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        valid_op;
  logic        misalign;
  logic        oor;
  logic        err;
  logic        accept;
  logic [31:0] load_val;
  assign bus.req_ready = (state == IDLE) && RST_N;
  assign accept = bus.req_valid && bus.req_ready;
  always_comb begin
`ifdef LSU_SUBWORD_EN
    valid_op = bus.req_store ? bus.req_funct3 inside {3'b000, 3'b001, 3'b010}
                             : bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`else
    valid_op = bus.req_funct3 == 3'b010;
`endif
    misalign = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
               (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    oor = bus.req_addr[31:2] >= 30'(MEM_WORDS);
    err = !valid_op || misalign || oor;
  end
`ifdef LSU_SUBWORD_EN
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] merged;
  logic        unused_cap;
  assign unused_cap = ^{st, addr[31:2]};
  always_comb begin
    lane_b = RD[{addr[1:0], 3'b000} +: 8];
    lane_h = RD[{addr[1], 4'b0000} +: 16];
    load_val = (f3 == 3'b000) ? {{24{lane_b[7]}}, lane_b} :
               (f3 == 3'b001) ? {{16{lane_h[15]}}, lane_h} :
               (f3 == 3'b100) ? {24'd0, lane_b} :
               (f3 == 3'b101) ? {16'd0, lane_h} : RD;
    merged = RD;
    if (f3[0])
      merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    else
      merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
  end
`else
  logic unused_cap;
  assign unused_cap = ^{st, f3, addr, wdata};
  assign load_val = RD;
`endif
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      st         <= 1'b0;
      f3         <= 3'd0;
      addr       <= 32'd0;
      wdata      <= 32'd0;
      WE         <= 1'b0;
      A          <= 32'd0;
      WD         <= 32'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          st    <= bus.req_store;
          f3    <= bus.req_funct3;
          addr  <= bus.req_addr;
          wdata <= bus.req_wdata;
          if (err) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= 32'd0;
          end else if (!bus.req_store) begin
            state <= READ;
            A     <= {bus.req_addr[31:2], 2'b00};
          end else if (bus.req_funct3 == 3'b010) begin
            state <= WRITE;
            A     <= {bus.req_addr[31:2], 2'b00};
            WE    <= 1'b1;
            WD    <= bus.req_wdata;
          end else begin
            state <= RMW_RD;
            A     <= {bus.req_addr[31:2], 2'b00};
          end
        end
        READ: begin
          state          <= RESP;
          A              <= 32'd0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= load_val;
        end
`ifdef LSU_SUBWORD_EN
        RMW_RD: begin
          state <= WRITE;
          WE    <= 1'b1;
          WD    <= merged;
        end
`endif
        WRITE: begin
          state          <= RESP;
          WE             <= 1'b0;
          WD             <= 32'd0;
          A              <= 32'd0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= 32'd0;
        end
        RESP: if (bus.resp_ready) begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= 32'd0;
        end
        default: begin
          state <= IDLE;
          WE    <= 1'b0;
          A     <= 32'd0;
          WD    <= 32'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, corner sequences and random ops against a word-array reference model.
module tb_load_store_unit;
  localparam int MW = 15;
`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        WE;
  logic [31:0] A, WD, RD;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int n_cmp = 0;
  int n_fail = 0;
  load_store_unit_if bus();
  load_store_unit #(.MEM_WORDS(MW)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus), .WE(WE), .A(A), .WD(WD), .RD(RD)
  );
  always #5 CLK = ~CLK;
  assign RD = mem[A[5:2]];
  always @(posedge CLK) if (WE) mem[A[5:2]] <= WD;
  typedef struct {
    bit st; logic [2:0] f3; logic [31:0] ad; logic [31:0] wd;
    bit e; logic [31:0] rd; int lat; int wen; logic [31:0] wa; logic [31:0] wdv;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(bit st, logic [2:0] f3, logic [31:0] ad, logic [31:0] wd,
                              bit e, logic [31:0] rd, int lat, int wen, logic [31:0] wa, logic [31:0] wdv);
    vec_t v;
    v.st = st; v.f3 = f3; v.ad = ad; v.wd = wd; v.e = e; v.rd = rd;
    v.lat = lat; v.wen = wen; v.wa = wa; v.wdv = wdv;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void ref_op(input bit st, input logic [2:0] f3, input logic [31:0] ad,
                                 input logic [31:0] wd, output bit e, output logic [31:0] rd,
                                 output int lat, output int wen, output logic [31:0] nw);
    int size;
    bit ok;
    logic [31:0] word, v, m;
    int sh;
    size = 1 << f3[1:0];
    ok = SUB ? (st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7)) : (f3 == 3'd2);
    e = !ok || (ad % size) != 0 || (ad / 4) >= MW;
    word = ref_mem[ad[5:2]];
    sh = int'(ad % 4) * 8;
    rd = 32'd0; nw = word; lat = 1; wen = 0;
    if (!e && !st) begin
      v = word >> sh;
      if (size < 4) begin
        v = v % (32'd1 << (8 * size));
        if (f3 < 3'd4 && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
      end
      rd = v; lat = 2;
    end
    if (!e && st) begin
      if (size == 4) nw = wd;
      else begin
        m = ((32'd1 << (8 * size)) - 32'd1) << sh;
        nw = (word & ~m) | ((wd << sh) & m);
      end
      lat = (size == 4) ? 2 : 3;
      wen = 1;
    end
  endfunction
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd,
                       input int hold, output bit e, output logic [31:0] rd, output int lat,
                       output int wen, output logic [31:0] wa, output logic [31:0] wdv);
    @(negedge CLK);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = ad; bus.req_wdata = wd; bus.resp_ready = (hold == 0);
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    lat = 1; wen = 0; wa = 32'd0; wdv = 32'd0;
    while (!bus.resp_valid && lat < 10) begin
      if (WE) begin wen++; wa = A; wdv = WD; end
      @(posedge CLK); #1;
      lat++;
    end
    if (!bus.resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    e = bus.resp_err; rd = bus.resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, rd);
      chk("hold_err", 32'(bus.resp_err), 32'(e));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      if (WE) wen++;
    end
    bus.resp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("resp_drop", 32'(bus.resp_valid), 32'd0);
    chk("idle_A", A, 32'd0);
  endtask
  task automatic run_model(input bit st, input logic [2:0] f3, input logic [31:0] ad,
                           input logic [31:0] wd, input int hold);
    bit e, me; logic [31:0] rd, mrd, wa, wdv, nw; int lat, wen, mlat, mwen;
    ref_op(st, f3, ad, wd, me, mrd, mlat, mwen, nw);
    do_op(st, f3, ad, wd, hold, e, rd, lat, wen, wa, wdv);
    chk("rnd_err", 32'(e), 32'(me));
    chk("rnd_rdata", rd, mrd);
    chk("rnd_lat", 32'(lat), 32'(mlat));
    chk("rnd_we_cycles", 32'(wen), 32'(mwen));
    if (mwen == 1) begin
      chk("rnd_A", wa, {ad[31:2], 2'b00});
      chk("rnd_WD", wdv, nw);
      ref_mem[ad[5:2]] = nw;
    end
  endtask
  initial begin
    bit e, me; logic [31:0] rd, mrd, wa, wdv, nw; int lat, wen, mlat, mwen;
    logic [2:0] f3; logic [31:0] ad; bit st;
    for (int i = 0; i < 16; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_WE", 32'(WE), 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_WD", WD, 32'd0);
    @(negedge CLK); RST_N = 1'b1;
    tbl.push_back(mk(1, 3'b010, 32'h8, 32'hDEADBEEF, 0, 0, 2, 1, 32'h8, 32'hDEADBEEF));
    tbl.push_back(mk(0, 3'b010, 32'h8, 0, 0, 32'hDEADBEEF, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 32'hB, 0, !SUB, SUB ? 32'hFFFFFFDE : 0, SUB ? 2 : 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b100, 32'hB, 0, !SUB, SUB ? 32'h000000DE : 0, SUB ? 2 : 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b101, 32'h8, 0, !SUB, SUB ? 32'h0000BEEF : 0, SUB ? 2 : 1, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 32'h9, 32'hAB00CD55, !SUB, 0, SUB ? 3 : 1, SUB ? 1 : 0,
                     SUB ? 32'h8 : 0, SUB ? 32'hDEAD55EF : 0));
    tbl.push_back(mk(0, 3'b010, 32'h8, 0, 0, SUB ? 32'hDEAD55EF : 32'hDEADBEEF, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h6, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h3C, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 32'h0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 32'h1, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3'b010, 32'h38, 32'h12345678, 0, 0, 2, 1, 32'h38, 32'h12345678));
    tbl.push_back(mk(0, 3'b010, 32'h38, 0, 0, 32'h12345678, 2, 0, 0, 0));
    tbl.push_back(mk(1, 3'b001, 32'hA, 32'h99997777, !SUB, 0, SUB ? 3 : 1, SUB ? 1 : 0,
                     SUB ? 32'h8 : 0, SUB ? 32'h777755EF : 0));
    tbl.push_back(mk(0, 3'b001, 32'hA, 0, !SUB, SUB ? 32'h00007777 : 0, SUB ? 2 : 1, 0, 0, 0));
    tbl.push_back(mk(1, 3'b010, 32'h3C, 32'h1, 1, 0, 1, 0, 0, 0));
    foreach (tbl[i]) begin
      ref_op(tbl[i].st, tbl[i].f3, tbl[i].ad, tbl[i].wd, me, mrd, mlat, mwen, nw);
      do_op(tbl[i].st, tbl[i].f3, tbl[i].ad, tbl[i].wd, 0, e, rd, lat, wen, wa, wdv);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_we_cycles", i), 32'(wen), 32'(tbl[i].wen));
      if (tbl[i].wen == 1) begin
        chk($sformatf("tbl%0d_A", i), wa, tbl[i].wa);
        chk($sformatf("tbl%0d_WD", i), wdv, tbl[i].wdv);
      end
      if (!me && tbl[i].st) ref_mem[tbl[i].ad[5:2]] = nw;
    end
    do_op(0, 3'b010, 32'h38, 0, 4, e, rd, lat, wen, wa, wdv);
    chk("stall_rdata", rd, 32'h12345678);
    chk("stall_we", 32'(wen), 32'd0);
    @(negedge CLK);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'hA5A5A5A5; bus.resp_ready = 1'b1;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    chk("rstw_we_before", 32'(WE), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rstw_we_drop", 32'(WE), 32'd0);
    chk("rstw_A", A, 32'd0);
    chk("rstw_WD", WD, 32'd0);
    chk("rstw_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rstw_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw_no_resp", 32'(bus.resp_valid), 32'd0);
    chk("rstw_no_we", 32'(WE), 32'd0);
    run_model(0, 3'b010, 32'h10, 0, 0);
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, MW * 4 + 7));
      if ($urandom_range(0, 2) == 0) ad = ad & ~32'd3;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end
      run_model(st, f3, ad, $urandom, $urandom_range(0, 3) == 0 ? 2 : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
